pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with a multi-cycle mult/div freeze FSM.
// Optional stalled-cycle counter enabled by defining STALL_CNT_EN.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdu1_block,
  input  logic        hdu2_block,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        branch_taken,
  output logic        PcStall,
  output logic        IF_ID_Stall,
  output logic        ID_EX_Stall,
  output logic        ID_EX_Flush,
  output logic        IF_ID_Flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The accept cycle counts as the first freeze cycle, so BUSY runs N-1 cycles.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] cnt_r;
  logic [5:0] cnt_nxt_s;
  logic       accept_s;
  logic       freeze_s;
  logic       hazard_s;

  assign accept_s = (state_r != BUSY) & md_start & ~rst;
  assign freeze_s = accept_s | ((state_r == BUSY) & ~rst);
  assign hazard_s = hdu1_block | hdu2_block;

  // State and down-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (md_start) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = md_is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      BUSY: begin
        cnt_nxt_s = cnt_r - 6'd1;
        if (cnt_r == 6'd1) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 6'd0;
      end
    endcase
  end

  // Control outputs: freeze > hazard stall > branch flush
  always_comb begin
    PcStall     = 1'b0;
    IF_ID_Stall = 1'b0;
    ID_EX_Stall = 1'b0;
    ID_EX_Flush = 1'b0;
    IF_ID_Flush = 1'b0;
    md_busy     = freeze_s;
    md_done     = (state_r == DONE) & ~rst;
    if (freeze_s) begin
      PcStall     = 1'b1;
      IF_ID_Stall = 1'b1;
      ID_EX_Stall = 1'b1;
    end else if (hazard_s) begin
      PcStall     = 1'b1;
      IF_ID_Stall = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      IF_ID_Flush = branch_taken;
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if (PcStall && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (default parameters).
// Build with STALL_CNT_EN defined to also exercise counter saturation.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, hdu1_block, hdu2_block, md_start, md_is_div, branch_taken;
  logic        PcStall, IF_ID_Stall, ID_EX_Stall, ID_EX_Flush, IF_ID_Flush;
  logic        md_busy, md_done;
  logic [15:0] stall_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_stall = 16'd0;

  // {PcStall, IF_ID_Stall, ID_EX_Stall, ID_EX_Flush, IF_ID_Flush, md_busy, md_done}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] FRZ   = 7'b1110010;
  localparam logic [6:0] HAZ   = 7'b1101000;
  localparam logic [6:0] BR    = 7'b0000100;
  localparam logic [6:0] DN    = 7'b0000001;
  localparam logic [6:0] DNFRZ = 7'b1110011;
  localparam logic [6:0] DNHAZ = 7'b1101001;

  logic [6:0] outs;
  assign outs = {PcStall, IF_ID_Stall, ID_EX_Stall, ID_EX_Flush, IF_ID_Flush, md_busy, md_done};

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .hdu1_block(hdu1_block), .hdu2_block(hdu2_block),
    .md_start(md_start), .md_is_div(md_is_div), .branch_taken(branch_taken),
    .PcStall(PcStall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall),
    .ID_EX_Flush(ID_EX_Flush), .IF_ID_Flush(IF_ID_Flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected counter after a clock edge given the cycle's reset and expected PcStall.
  task automatic model_edge(input logic r, input logic pc);
    if (r) begin
      exp_stall = 16'd0;
    end else begin
`ifdef STALL_CNT_EN
      if (pc && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input logic r, h1, h2, ms, dv, br, input logic [6:0] exp, input string tag);
    rst = r; hdu1_block = h1; hdu2_block = h2;
    md_start = ms; md_is_div = dv; branch_taken = br;
    @(negedge clk);
    check_eq(tag, {25'd0, outs}, {25'd0, exp});
    check_eq({tag, "_cnt"}, {16'd0, stall_cnt}, {16'd0, exp_stall});
    @(posedge clk);
    model_edge(r, exp[6]);
    #1;
  endtask

  // Unchecked hazard-stall cycles used to push the counter toward saturation.
  task automatic run_haz(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; hdu1_block = 1'b1; hdu2_block = 1'b0;
      md_start = 1'b0; md_is_div = 1'b0; branch_taken = 1'b0;
      @(posedge clk);
      model_edge(1'b0, 1'b1);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; hdu1_block = 1'b0; hdu2_block = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: outputs quiet except hazard/branch paths; md_start ignored
    step(1, 0, 0, 0, 0, 0, NONE, "rst_idle");
    step(1, 1, 0, 0, 0, 1, HAZ,  "rst_haz");
    step(1, 0, 0, 1, 1, 0, NONE, "rst_mdstart");
    step(1, 0, 0, 0, 0, 1, BR,   "rst_br");

    // Multiply: 4 freeze cycles, done on cycle 5, then idle
    step(0, 0, 0, 1, 0, 0, FRZ, "mul_c1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, FRZ, "mul_busy");
    step(0, 0, 0, 0, 0, 0, DN,   "mul_done");
    step(0, 0, 0, 0, 0, 0, NONE, "mul_idle");

    // Divide with load-use hazard throughout: freeze wins for 32 cycles
    step(0, 0, 1, 1, 1, 0, FRZ, "div_c1");
    for (int i = 0; i < 31; i++) step(0, 0, 1, 0, 0, 0, FRZ, "div_busy");
    step(0, 0, 1, 0, 0, 0, DNHAZ, "div_c33");
    step(0, 0, 1, 0, 0, 0, HAZ,   "div_c34");

    // Hazard beats branch; branch alone flushes IF/ID
    step(0, 1, 0, 0, 0, 1, HAZ,  "haz_br");
    step(0, 0, 0, 0, 0, 1, BR,   "br_only");
    step(0, 0, 0, 0, 0, 0, NONE, "quiet");

    // Back-to-back multiplies: start held during BUSY is ignored
    step(0, 0, 0, 1, 0, 0, FRZ, "b2b_c1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1, FRZ, "b2b_busy_ign");
    step(0, 0, 0, 1, 0, 0, DNFRZ, "b2b_done_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, FRZ, "b2b_busy2");
    step(0, 0, 0, 0, 0, 0, DN,   "b2b_done2");
    step(0, 0, 0, 0, 0, 0, NONE, "b2b_idle");

    // Reset on cycle 10 of a divide aborts it with no done pulse
    step(0, 0, 0, 1, 1, 0, FRZ, "rdiv_c1");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, FRZ, "rdiv_busy");
    step(1, 0, 0, 0, 0, 0, NONE, "rdiv_rst");
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 0, NONE, "rdiv_after");
    check_eq("rdiv_stall_cnt", {16'd0, stall_cnt}, 32'd0);

`ifdef STALL_CNT_EN
    // Drive the counter to near saturation, then past it
    run_haz(65532);
    check_eq("sat_preload", {16'd0, stall_cnt}, 32'd65532);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, HAZ, "sat_haz");
    check_eq("sat_reached", {16'd0, stall_cnt}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, HAZ, "sat_hold");
    check_eq("sat_held", {16'd0, stall_cnt}, 32'h0000FFFF);
`else
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, HAZ, "nocnt_haz");
    check_eq("nocnt_zero", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
